// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the load/store responder: funct3 codes, FSM states,
// lane-mask decode and access legality check.
package data_mem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte lanes touched by an access; funct3[1:0] gives the size.
  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   lane_mask = 4'b0001 << a;
      2'b01:   lane_mask = 4'b0011 << {a[1], 1'b0};
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Illegal funct3 for the direction, or an address not aligned to the size.
  function automatic logic access_err(input logic wr, input logic [2:0] f3, input logic [1:0] a);
    logic bad_f3;
    logic misal;
    bad_f3 = wr ? (f3 > F3_W) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    misal  = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    return bad_f3 | misal;
  endfunction

endpackage

// File: rtl/data_mem_responder_byte_lane_ram.sv
// Four independent byte banks sharing a word index. Write data arrives already
// placed in its lanes; read is asynchronous over the full word.
module byte_lane_ram
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                      clk,
  input  logic [ADDR_W-3:0]         i_idx,
  input  logic [NUM_LANES-1:0]      i_we,
  input  logic [NUM_LANES-1:0][7:0] i_wdata,
  output logic [NUM_LANES-1:0][7:0] o_rdata
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] r_mem [DEPTH];

    // Per-lane byte write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
      if (i_we[l]) r_mem[i_idx] <= i_wdata[l];
    end

    assign o_rdata[l] = r_mem[i_idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one request at a time, fixed wait states, then a
// little-endian B/H/W access into byte-lane RAM with a held response.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e              r_state, w_next;
  logic [3:0]          r_cnt;
  logic                r_write;
  logic [2:0]          r_f3;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_err;

  logic                w_accept, w_commit;
  logic                w_wr;
  logic [2:0]          w_f3;
  logic [ADDR_W-1:0]   w_addr;
  logic [31:0]         w_wd;
  logic                w_err;
  logic [NUM_LANES-1:0] w_we;
  logic [31:0]         w_lane_wd, w_word, w_ldata;
  logic [7:0]          w_b;
  logic [15:0]         w_h;

  assign w_accept = req_valid & req_ready;

  // With no wait states the access happens on the accepting edge, so it must
  // use the live request; otherwise the latched copy is used.
  assign w_wr   = (r_state == ST_IDLE) ? req_write  : r_write;
  assign w_f3   = (r_state == ST_IDLE) ? req_funct3 : r_f3;
  assign w_addr = (r_state == ST_IDLE) ? req_addr   : r_addr;
  assign w_wd   = (r_state == ST_IDLE) ? req_wdata  : r_wdata;

  assign w_err = access_err(w_wr, w_f3, w_addr[1:0]);
  assign w_we  = (w_commit && w_wr && !w_err) ? lane_mask(w_f3, w_addr[1:0]) : '0;

  // Replicate store data across lanes; the mask picks the live ones.
  always_comb begin
    case (w_f3[1:0])
      2'b00:   w_lane_wd = {4{w_wd[7:0]}};
      2'b01:   w_lane_wd = {2{w_wd[15:0]}};
      default: w_lane_wd = w_wd;
    endcase
  end

  byte_lane_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .i_idx   (w_addr[ADDR_W-1:2]),
    .i_we    (w_we),
    .i_wdata (w_lane_wd),
    .o_rdata (w_word)
  );

  assign w_b = w_word[{w_addr[1:0], 3'b000} +: 8];
  assign w_h = w_addr[1] ? w_word[31:16] : w_word[15:0];

  // Lane select and sign/zero extension of load data.
  always_comb begin
    case (w_f3)
      F3_B:    w_ldata = {{24{w_b[7]}}, w_b};
      F3_BU:   w_ldata = {24'd0, w_b};
      F3_H:    w_ldata = {{16{w_h[15]}}, w_h};
      F3_HU:   w_ldata = {16'd0, w_h};
      default: w_ldata = w_word;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next state, handshake outputs and the commit strobe (edge entering RESP).
  always_comb begin
    w_next    = r_state;
    w_commit  = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_next   = ST_RESP;
            w_commit = 1'b1;
          end else begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next   = ST_RESP;
          w_commit = 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch, wait counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_accept) begin
        r_write <= req_write;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= CNT_INIT;
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (w_wr || w_err) ? 32'd0 : w_ldata;
      end
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
